// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM encoding and a width helper.
package apb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERRRSP = 2'd3;

  // Number of bits needed to hold values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Slave decoder: the upper SWIDTH address bits pick a slave; indices at or
// above NSLV are unmapped and produce no select.
module apb_addr_decode #(
  parameter int AWIDTH = 8,
  parameter int SWIDTH = 2,
  parameter int NSLV   = 4
) (
  input  logic [AWIDTH-1:0] addr,
  output logic [NSLV-1:0]   sel,
  output logic              hit
);

  logic [SWIDTH-1:0] idx;
  logic              unused_addr_bits;

  assign idx              = addr[AWIDTH-1 -: SWIDTH];
  assign hit              = (int'(idx) < NSLV);
  assign unused_addr_bits = ^addr;

  // One-hot select for a mapped index, all-zero otherwise.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (hit && (int'(idx) == i)) sel[i] = 1'b1;
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB requester: one command in, SETUP/ACCESS on the bus, one response out.
//
//   state  | meaning
//   IDLE   | ready for a command, bus idle
//   SETUP  | PSEL asserted, PENABLE low, one cycle
//   ACCESS | PENABLE high, waiting for PREADY or timeout
//   ERRRSP | unmapped address, error response without a bus cycle
module apb_master
  import apb_pkg::*;
#(
  parameter int DWIDTH  = 8,
  parameter int AWIDTH  = 8,
  parameter int NSLV    = 4,
  parameter int SWIDTH  = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [AWIDTH-1:0]      cmd_addr,
  input  logic [DWIDTH-1:0]      cmd_wdata,
  output logic                   rsp_valid,
  output logic [DWIDTH-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [AWIDTH-1:0]      PADDR,
  output logic [NSLV-1:0]        PSEL,
  output logic                   PENABLE,
  output logic                   PWRITE,
  output logic [DWIDTH-1:0]      PWDATA,
  input  logic [NSLV*DWIDTH-1:0] PRDATA,
  input  logic [NSLV-1:0]        PREADY,
  input  logic [NSLV-1:0]        PSLVERR
);

  localparam int                CWIDTH   = clog2(TIMEOUT + 1);
  localparam logic [CWIDTH-1:0] CNT_LAST = CWIDTH'(TIMEOUT - 1);

  logic [1:0]        state;
  logic              lat_write;
  logic [AWIDTH-1:0] lat_addr;
  logic [DWIDTH-1:0] lat_wdata;
  logic [NSLV-1:0]   lat_sel;
  logic [CWIDTH-1:0] wait_cnt;

  logic [NSLV-1:0]   dec_sel;
  logic              dec_hit;
  logic              slv_ready;
  logic              slv_err;
  logic [DWIDTH-1:0] slv_rdata;

  apb_addr_decode #(
    .AWIDTH(AWIDTH),
    .SWIDTH(SWIDTH),
    .NSLV  (NSLV)
  ) u_decode (
    .addr(cmd_addr),
    .sel (dec_sel),
    .hit (dec_hit)
  );

  assign cmd_ready = (state == IDLE);
  assign PSEL      = ((state == SETUP) || (state == ACCESS)) ? lat_sel : '0;
  assign PENABLE   = (state == ACCESS);
  assign PADDR     = lat_addr;
  assign PWRITE    = lat_write;
  assign PWDATA    = lat_wdata;

  // Pick ready/error/read data of the latched slave using its one-hot select.
  always_comb begin
    slv_rdata = '0;
    for (int i = 0; i < NSLV; i++) begin
      if (lat_sel[i]) slv_rdata = slv_rdata | PRDATA[i*DWIDTH +: DWIDTH];
    end
    slv_ready = |(PREADY & lat_sel);
    slv_err   = |(PSLVERR & lat_sel);
  end

  // Transfer sequencing, wait counting and response registers.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state     <= IDLE;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_sel   <= '0;
      wait_cnt  <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            lat_write <= cmd_write;
            lat_addr  <= cmd_addr;
            lat_wdata <= cmd_write ? cmd_wdata : '0;
            lat_sel   <= dec_sel;
            wait_cnt  <= '0;
            state     <= dec_hit ? SETUP : ERRRSP;
          end
        end
        SETUP: state <= ACCESS;
        ACCESS: begin
          if (slv_ready) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= lat_write ? '0 : slv_rdata;
            rsp_err   <= slv_err;
            state     <= IDLE;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            state     <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CWIDTH'(1);
          end
        end
        ERRRSP: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= '0;
          rsp_err   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: directed cases plus random commands,
// with expected bus activity and responses derived from transfer rules.
module tb_apb_master;

  localparam int TO = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [7:0]  cmd_addr = 8'h00;
  logic [7:0]  cmd_wdata = 8'h00;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [7:0]  PADDR;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PWDATA;
  logic [31:0] PRDATA = 32'h0;
  logic [3:0]  PREADY = 4'hF;
  logic [3:0]  PSLVERR = 4'h0;

  logic        u_cmd_valid = 1'b0;
  logic        u_cmd_ready;
  logic        u_rsp_valid;
  logic [7:0]  u_rsp_rdata;
  logic        u_rsp_err;
  logic [7:0]  u_paddr;
  logic [2:0]  u_psel;
  logic        u_penable;
  logic        u_pwrite;
  logic [7:0]  u_pwdata;
  logic [23:0] u_prdata = 24'h3C_1122;
  logic [2:0]  u_pready = 3'b111;
  logic [2:0]  u_pslverr = 3'b000;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  last_rd = 8'h00;
  logic        last_err = 1'b0;

  always #5 PCLK = ~PCLK;

  apb_master #(.DWIDTH(8), .AWIDTH(8), .NSLV(4), .SWIDTH(2), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master #(.DWIDTH(8), .AWIDTH(8), .NSLV(3), .SWIDTH(2), .TIMEOUT(TO)) dut3 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(u_cmd_valid), .cmd_ready(u_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(u_rsp_valid), .rsp_rdata(u_rsp_rdata), .rsp_err(u_rsp_err),
    .PADDR(u_paddr), .PSEL(u_psel), .PENABLE(u_penable), .PWRITE(u_pwrite), .PWDATA(u_pwdata),
    .PRDATA(u_prdata), .PREADY(u_pready), .PSLVERR(u_pslverr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One quiet cycle: no response, bus idle, response fields hold.
  task automatic idle_cycle();
    @(negedge PCLK);
    check("idle_rsp_valid", rsp_valid, 0);
    check("idle_rsp_rdata_hold", rsp_rdata, last_rd);
    check("idle_rsp_err_hold", rsp_err, last_err);
    check("idle_psel", PSEL, 0);
    check("idle_penable", PENABLE, 0);
  endtask

  // Issue one command at the current negedge (block must be idle) and follow
  // it to its response. Returns at the negedge of the response cycle so the
  // next command can be presented in that same cycle.
  task automatic run_cmd(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                         input int waits, input logic slverr,
                         input bit use_pat, input logic [31:0] pat);
    int         idx;
    int         lat;
    logic       tmo;
    logic [3:0] onehot;
    logic [7:0] slot [4];
    logic [7:0] exp_rd;
    logic       exp_err;
    logic [31:0] rnd;

    idx    = int'(addr[7:6]);
    onehot = 4'b0001 << idx;
    tmo    = (waits >= TO);
    lat    = tmo ? (2 + TO) : (3 + waits);
    for (int s = 0; s < 4; s++) begin
      rnd     = $urandom;
      slot[s] = use_pat ? pat[s*8 +: 8] : rnd[7:0];
    end
    exp_rd  = (wr || tmo) ? 8'h00 : slot[idx];
    exp_err = tmo || slverr;

    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    for (int s = 0; s < 4; s++) PRDATA[s*8 +: 8] = slot[s];
    PREADY       = 4'($urandom);
    PSLVERR      = 4'($urandom);
    PSLVERR[idx] = slverr;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = 8'($urandom);
    cmd_wdata = 8'($urandom);

    for (int k = 1; k <= lat; k++) begin
      if (k < lat) begin
        check("busy_rsp_valid", rsp_valid, 0);
        check("psel", PSEL, onehot);
        check("penable", PENABLE, (k >= 2));
        check("paddr", PADDR, addr);
        check("pwrite", PWRITE, wr);
        check("pwdata", PWDATA, wr ? wd : 8'h00);
        check("cmd_ready_busy", cmd_ready, 0);
        PREADY      = 4'($urandom);
        PREADY[idx] = (k >= 2) && ((k - 2) >= waits);
        @(negedge PCLK);
      end else begin
        check("rsp_valid", rsp_valid, 1);
        check("rsp_err", rsp_err, exp_err);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_psel", PSEL, 0);
        check("rsp_penable", PENABLE, 0);
        check("rsp_cmd_ready", cmd_ready, 1);
      end
    end
    last_rd  = exp_rd;
    last_err = exp_err;
  endtask

  initial begin
    logic        r_wr;
    logic [7:0]  r_addr;
    logic [7:0]  r_wd;
    int          r_waits;
    logic        r_err;

    repeat (2) @(negedge PCLK);
    check("rst_psel", PSEL, 0);
    check("rst_penable", PENABLE, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_paddr", PADDR, 0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Directed: write, read-back pattern, wait states, timeout, boundary, slave error.
    run_cmd(1'b1, 8'h40, 8'hA5, 0, 1'b0, 1'b0, 32'h0);
    run_cmd(1'b0, 8'h40, 8'h00, 0, 1'b0, 1'b1, 32'hFFFF_A5FF);
    run_cmd(1'b0, 8'hC0, 8'h00, 3, 1'b0, 1'b0, 32'h0);
    run_cmd(1'b0, 8'h80, 8'h00, TO, 1'b0, 1'b0, 32'h0);
    run_cmd(1'b1, 8'h81, 8'h3C, 0, 1'b0, 1'b0, 32'h0);
    run_cmd(1'b0, 8'h82, 8'h00, TO - 1, 1'b0, 1'b0, 32'h0);
    run_cmd(1'b1, 8'h00, 8'h5A, 0, 1'b1, 1'b0, 32'h0);
    idle_cycle();

    // Random commands, sometimes back-to-back, sometimes with gaps.
    for (int n = 0; n < 30; n++) begin
      r_wr    = 1'($urandom);
      r_addr  = 8'($urandom);
      r_wd    = 8'($urandom);
      r_waits = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 5) : 0;
      r_err   = ($urandom_range(0, 3) == 0);
      run_cmd(r_wr, r_addr, r_wd, r_waits, r_err, 1'b0, 32'h0);
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // Reset in the middle of ACCESS: bus drops, no response afterwards.
    check("mid_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'hC0;
    PREADY    = 4'h0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("mid_penable_before", PENABLE, 1);
    check("mid_psel_before", PSEL, 4'b1000);
    PRESETn = 1'b0;
    @(negedge PCLK);
    check("mid_rst_psel", PSEL, 0);
    check("mid_rst_penable", PENABLE, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_rdata", rsp_rdata, 0);
    check("mid_rst_rsp_err", rsp_err, 0);
    PRESETn = 1'b1;
    PREADY  = 4'hF;
    last_rd  = 8'h00;
    last_err = 1'b0;
    @(negedge PCLK);
    check("mid_release_cmd_ready", cmd_ready, 1);
    repeat (3) idle_cycle();

    // Three-slave instance: unmapped index 3 errors at N+2 with no bus cycle.
    check("u_cmd_ready", u_cmd_ready, 1);
    u_cmd_valid = 1'b1;
    cmd_write   = 1'b0;
    cmd_addr    = 8'hC0;
    @(negedge PCLK);
    u_cmd_valid = 1'b0;
    check("u_err_psel", u_psel, 0);
    check("u_err_penable", u_penable, 0);
    check("u_err_rsp_early", u_rsp_valid, 0);
    @(negedge PCLK);
    check("u_err_rsp_valid", u_rsp_valid, 1);
    check("u_err_rsp_err", u_rsp_err, 1);
    check("u_err_rsp_rdata", u_rsp_rdata, 0);
    check("u_err_cmd_ready", u_cmd_ready, 1);

    // Three-slave instance: mapped slot 2 still works.
    u_cmd_valid = 1'b1;
    cmd_addr    = 8'h80;
    @(negedge PCLK);
    u_cmd_valid = 1'b0;
    check("u_setup_psel", u_psel, 3'b100);
    @(negedge PCLK);
    check("u_access_penable", u_penable, 1);
    @(negedge PCLK);
    check("u_rd_rsp_valid", u_rsp_valid, 1);
    check("u_rd_rsp_rdata", u_rsp_rdata, 8'h3C);
    check("u_rd_rsp_err", u_rsp_err, 0);

    // Main instance keeps working after the mid-transfer reset.
    run_cmd(1'b0, 8'h7F, 8'h00, 1, 1'b0, 1'b0, 32'h0);
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB requester stage sitting directly upstream of the register slaves.
- Accepts single read/write commands on a valid/ready interface and runs the APB SETUP/ACCESS protocol.
- Decodes the target slave from the upper address bits and drives one-hot PSEL.
- Returns one response per command, carrying read data and an error flag. Errors are slave PSLVERR, wait timeout, or unmapped address.

Parameters:
- DWIDTH, 8, data width of PWDATA/PRDATA/cmd/rsp data.
- AWIDTH, 8, address width.
- NSLV, 4, number of slaves (1..2^SWIDTH).
- SWIDTH, 2, slave-index width; index = addr[AWIDTH-1 -: SWIDTH].
- TIMEOUT, 16, max ACCESS wait cycles with PREADY low before abort (>=1).

Ports:
- PCLK  in  1  clock, all logic on rising edge
- PRESETn  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  AWIDTH  target address
- cmd_wdata  in  DWIDTH  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DWIDTH  read data (0 for writes/errors)
- rsp_err  out  1  error flag, valid with rsp_valid
- PADDR  out  AWIDTH  APB address
- PSEL  out  NSLV  one-hot slave select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  DWIDTH  APB write data
- PRDATA  in  NSLV*DWIDTH  per-slave read data, slave i in slice [i*DWIDTH +: DWIDTH]
- PREADY  in  NSLV  per-slave ready; slaves without wait states tie high
- PSLVERR  in  NSLV  per-slave error; tie low if unused

Behaviour:
- Reset: PRESETn sampled low at a PCLK edge. All outputs go to 0 at that edge, except cmd_ready. State becomes IDLE and the wait counter clears.
  - Reset mid-transfer drops PSEL/PENABLE at that edge and no response is issued.
  - cmd_ready=1 from the first edge after PRESETn goes high.
- FSM states: IDLE, SETUP, ACCESS, ERRRSP.
- IDLE:
  - cmd_ready=1; PSEL=0, PENABLE=0.
  - On cmd_valid&&cmd_ready, latch write/addr/wdata.
  - Next state is SETUP if idx<NSLV, else ERRRSP.
- SETUP (exactly 1 cycle):
  - cmd_ready=0; PSEL[idx]=1, PENABLE=0.
  - PADDR=latched addr, PWRITE=latched write.
  - PWDATA=latched wdata for writes, 0 for reads.
  - Next state is ACCESS.
- ACCESS:
  - PENABLE=1; PSEL, PADDR, PWRITE, PWDATA held stable.
  - If PREADY[idx]=1: capture rdata = read ? PRDATA[idx slice] : 0 and err = PSLVERR[idx]. Go to IDLE; rsp_valid=1 on the following cycle.
  - Else the wait counter increments. When the counter reaches TIMEOUT with PREADY still low: abort, rsp_err=1, rsp_rdata=0, go to IDLE.
  - Wait counter width is clog2(TIMEOUT+1); it clears on entry to SETUP.
- ERRRSP (1 cycle): no PSEL asserted. rsp_valid=1, rsp_err=1, rsp_rdata=0 in the next cycle. Return to IDLE.
- Latency: accept at edge N; SETUP cycle N+1; ACCESS N+2; rsp_valid in cycle N+3 with zero wait states.
  - The FSM is back in IDLE in cycle N+3, so a new command may be accepted in the same cycle as rsp_valid.
  - Back-to-back throughput is one transfer per 3 cycles.
- rsp_valid is a single-cycle pulse with no backpressure. rsp_rdata/rsp_err hold their last values until the next response.
- PSEL/PENABLE never assert outside SETUP/ACCESS. At most one PSEL bit is set at any time.
- cmd inputs are ignored while cmd_ready=0.

Decomposition:
- Shared package/include apb_pkg:
  - FSM state encoding localparams (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, ERRRSP=2'd3).
  - clog2 function.
- Sub-module apb_addr_decode (combinational): addr -> one-hot sel[NSLV] plus hit flag. Reused later by the interconnect.

Test Plan:
- Write 0xA5 to addr 0x40, PREADY=4'hF: PSEL=4'b0010 with PENABLE=0 one cycle, then PENABLE=1 one cycle, PWDATA=0xA5 both; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read addr 0x40, PRDATA slot1=0xA5, others 0xFF: PWDATA=0, PWRITE=0; rsp_rdata=0xA5, rsp_err=0.
- Read addr 0xC0, PREADY[3] low 3 cycles: ACCESS lasts 4 cycles with PADDR=0xC0 and PSEL=4'b1000 stable; rsp at N+6 with slot3 data.
- PREADY[2] stuck low, addr 0x80, TIMEOUT=16: abort after 16 wait cycles, rsp_err=1, rsp_rdata=0; next command accepted normally.
- PSLVERR[0]=1 on write to 0x00: rsp_err=1. Instance with NSLV=3 and addr 0xC0: PSEL stays 0, rsp_err=1 at N+2.
- Assert PRESETn=0 during ACCESS: PSEL=0, PENABLE=0, rsp_valid=0 at that edge; no response after release; cmd_ready=1.
